// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter in front of a single-port RAM.
// Masters use a valid/ready handshake with byte strobes; the slave side uses
// the cs/we/address/write_data/read_data/ready core interface.
// Optional access timeout: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 15,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERROR_DATA     = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_valid,
    input  logic [3:0]            m0_wstrb,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic [31:0]           m0_rdata,
    output logic                  m0_ready,
    input  logic                  m1_valid,
    input  logic [3:0]            m1_wstrb,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic [31:0]           m1_rdata,
    output logic                  m1_ready,
    output logic                  mem_cs,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data,
    input  logic                  mem_ready,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        rr_last;   // id of the master granted most recently
    logic        grant;     // id of the master owning the current access
    logic        winner;
    logic        done;
    logic [31:0] done_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] to_cnt;
    logic [7:0] to_cnt_inc;

    assign to_cnt_inc = to_cnt + 8'd1;
`endif

    // Pick the winner: sole requester, or on a tie the master not served last
    always_comb begin
        winner = 1'b0;
        if (m0_valid && m1_valid) begin
            winner = ~rr_last;
        end else if (m1_valid) begin
            winner = 1'b1;
        end
    end

    // Access completion: slave ready, or (optionally) the timeout expiring
    always_comb begin
        done      = mem_ready;
        done_data = mem_read_data;
`ifdef MEM_ARB_TIMEOUT_EN
        if (!mem_ready && (to_cnt_inc == TO_LIMIT)) begin
            done      = 1'b1;
            done_data = ERROR_DATA;
        end
`endif
    end

    // Arbitration FSM with registered slave-side and master-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_last        <= 1'b1;
            grant          <= 1'b0;
            mem_cs         <= 1'b0;
            mem_we         <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            m0_rdata       <= '0;
            m1_rdata       <= '0;
            m0_ready       <= 1'b0;
            m1_ready       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt         <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant          <= winner;
                        rr_last        <= winner;
                        mem_address    <= winner ? m1_addr  : m0_addr;
                        mem_write_data <= winner ? m1_wdata : m0_wdata;
                        // mem_we doubles as the latched strobe register
                        mem_we         <= winner ? m1_wstrb : m0_wstrb;
                        mem_cs         <= 1'b1;
                        state          <= ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
                        to_cnt         <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (done) begin
                        mem_cs <= 1'b0;
                        mem_we <= '0;
                        if (grant) begin
                            m1_rdata <= done_data;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= done_data;
                            m0_ready <= 1'b1;
                        end
                        state <= RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                        if (!mem_ready) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt_inc;
`endif
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef MEM_ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected slave accesses
// and master responses; monitors pop and compare when the DUT presents them.
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif
    localparam logic [31:0] ED = 32'hBAD0BAD0;

    typedef struct {
        logic [14:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          cycles;   // expected cs-high cycles, -1 = unchecked
    } acc_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        int          lat;      // valid-to-ready cycles, -1 = unchecked
        logic        terr;
    } rsp_t;

    logic        clk, rst_n;
    logic        m0_valid, m1_valid;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [14:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        mem_cs;
    logic [3:0]  mem_we;
    logic [14:0] mem_address;
    logic [31:0] mem_write_data, mem_read_data;
    logic        mem_ready;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cyc [2];
    acc_t acc_q[$];
    rsp_t rsp_q[$];

    int          slave_delay = 1;   // 0 = never ready
    logic        slave_xor = 1'b0;
    logic [31:0] slave_data = '0;

    mem_arbiter #(
        .ADDR_WIDTH(15),
        .TIMEOUT_CYCLES(TO),
        .ERROR_DATA(ED)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_ready(mem_ready), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Slave model: ready slave_delay cycles after cs first appears
    initial begin
        int scnt;
        scnt = 0;
        mem_ready = 1'b0;
        mem_read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                scnt = 0;
            end else if (mem_cs) begin
                scnt++;
                if (slave_delay != 0 && scnt == slave_delay + 1) begin
                    mem_ready = 1'b1;
                    mem_read_data = slave_xor ? (slave_data ^ {17'd0, mem_address}) : slave_data;
                end
            end else begin
                scnt = 0;
            end
        end
    end

    // Slave-side monitor: access fields stable for the whole cs window
    initial begin
        acc_t cur;
        logic active;
        int   len;
        active = 1'b0;
        len = 0;
        cur = '{addr: '0, we: '0, wdata: '0, cycles: -1};
        forever begin
            @(negedge clk);
            if (mem_cs) begin
                if (!active) begin
                    active = 1'b1;
                    len = 0;
                    if (acc_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_access actual=%h required=none", mem_address);
                        cur = '{addr: mem_address, we: mem_we, wdata: mem_write_data, cycles: -1};
                    end else begin
                        cur = acc_q.pop_front();
                    end
                end
                len++;
                check("mem_address", 32'(mem_address), 32'(cur.addr));
                check("mem_we", 32'(mem_we), 32'(cur.we));
                check("mem_write_data", mem_write_data, cur.wdata);
            end else begin
                if (mem_we !== 4'b0) check("mem_we_idle", 32'(mem_we), 32'h0);
                if (active) begin
                    active = 1'b0;
                    if (cur.cycles >= 0) check("cs_cycles", len, cur.cycles);
                end
            end
        end
    end

    // Master-side monitor: every ready pulse matched against the scoreboard
    initial begin
        logic p0, p1;
        rsp_t r;
        int id;
        p0 = 1'b0;
        p1 = 1'b0;
        forever begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                id = m1_ready ? 1 : 0;
                check("single_grant_ready", 32'(m0_ready & m1_ready), 32'h0);
                check("ready_one_pulse", 32'(id ? p1 : p0), 32'h0);
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready actual=m%0d required=none", id);
                end else begin
                    r = rsp_q.pop_front();
                    check("grant_id", id, r.id);
                    check("rdata", id ? m1_rdata : m0_rdata, r.rdata);
                    check("timeout_err", 32'(timeout_err), 32'(r.terr));
                    if (r.lat >= 0) check("latency", cyc - issue_cyc[id], r.lat);
                end
            end
            p0 = m0_ready;
            p1 = m1_ready;
        end
    end

    // One master transaction: raise valid, wait for ready, drop valid
    task automatic txn(input int id, input logic [14:0] a, input logic [3:0] s, input logic [31:0] d);
        bit got;
        got = 0;
        if (id == 0) begin
            m0_addr = a; m0_wstrb = s; m0_wdata = d; m0_valid = 1'b1;
        end else begin
            m1_addr = a; m1_wstrb = s; m1_wdata = d; m1_valid = 1'b1;
        end
        issue_cyc[id] = cyc;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (id == 0 && m0_ready) begin
                got = 1; m0_valid = 1'b0;
            end
            if (id == 1 && m1_ready) begin
                got = 1; m1_valid = 1'b0;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL txn_timeout actual=no_ready required=m%0d_ready", id);
            if (id == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
        end
    endtask

    task automatic push_acc(input logic [14:0] a, input logic [3:0] w, input logic [31:0] d, input int c);
        acc_q.push_back('{addr: a, we: w, wdata: d, cycles: c});
    endtask

    task automatic push_rsp(input int id, input logic [31:0] d, input int lat, input logic te);
        rsp_q.push_back('{id: id, rdata: d, lat: lat, terr: te});
    endtask

    initial begin
        logic terr_exp;
        terr_exp = 1'b0;
        rst_n = 1'b0;
        m0_valid = 1'b0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_cs", 32'(mem_cs), 32'h0);
        check("rst_m0_ready", 32'(m0_ready), 32'h0);
        check("rst_m1_ready", 32'(m1_ready), 32'h0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_m1_rdata", m1_rdata, 32'h0);
        check("rst_mem_address", 32'(mem_address), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        #2 rst_n = 1'b1;

        // m0 read, single-cycle slave
        slave_delay = 1; slave_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        push_acc(15'h0010, 4'h0, 32'h0, 2);
        push_rsp(0, 32'hDEADBEEF, 3, terr_exp);
        txn(0, 15'h0010, 4'h0, 32'h0);

        // m1 partial write at the top address
        slave_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        push_acc(15'h7FFF, 4'b0101, 32'h11223344, 2);
        push_rsp(1, 32'hCAFEF00D, 3, terr_exp);
        txn(1, 15'h7FFF, 4'b0101, 32'h11223344);
        check("m0_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // Contention: both masters re-request back to back
        slave_xor = 1'b1; slave_data = 32'h55AA0000;
        @(posedge clk); #1;
        push_acc(15'h0100, 4'h0, 32'h000000A0, 2);
        push_acc(15'h0200, 4'hF, 32'h000000B0, 2);
        push_acc(15'h0101, 4'h0, 32'h000000A1, 2);
        push_acc(15'h0201, 4'hF, 32'h000000B1, 2);
        push_rsp(0, 32'h55AA0100, -1, terr_exp);
        push_rsp(1, 32'h55AA0200, -1, terr_exp);
        push_rsp(0, 32'h55AA0101, -1, terr_exp);
        push_rsp(1, 32'h55AA0201, -1, terr_exp);
        fork
            begin
                txn(0, 15'h0100, 4'h0, 32'h000000A0);
                txn(0, 15'h0101, 4'h0, 32'h000000A1);
            end
            begin
                txn(1, 15'h0200, 4'hF, 32'h000000B0);
                txn(1, 15'h0201, 4'hF, 32'h000000B1);
            end
        join

        // Slow slave: ready five cycles after cs
        slave_xor = 1'b0; slave_delay = 5; slave_data = 32'h13579BDF;
        @(posedge clk); #1;
        push_acc(15'h1234, 4'h0, 32'h0, 6);
        push_rsp(0, 32'h13579BDF, 7, terr_exp);
        txn(0, 15'h1234, 4'h0, 32'h0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Slave never answers: forced completion with error data
        slave_delay = 0;
        @(posedge clk); #1;
        terr_exp = 1'b1;
        push_acc(15'h0042, 4'h0, 32'h0, 4);
        push_rsp(0, ED, 5, terr_exp);
        txn(0, 15'h0042, 4'h0, 32'h0);
        slave_delay = 1; slave_data = 32'h00C0FFEE;
        @(posedge clk); #1;
        push_acc(15'h0043, 4'h3, 32'h77, 2);
        push_rsp(1, 32'h00C0FFEE, 3, terr_exp);
        txn(1, 15'h0043, 4'h3, 32'h77);
`endif

        // Reset in the middle of an access that never completes
        slave_delay = 0;
        @(posedge clk); #1;
        push_acc(15'h0777, 4'h0, 32'h0, -1);
        m0_addr = 15'h0777; m0_wstrb = 4'h0; m0_wdata = 32'h0; m0_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("cs_before_reset", 32'(mem_cs), 32'h1);
        #2;
        rst_n = 1'b0;
        m0_valid = 1'b0;
        terr_exp = 1'b0;
        #1;
        check("async_rst_mem_cs", 32'(mem_cs), 32'h0);
        check("async_rst_m0_ready", 32'(m0_ready), 32'h0);
        check("async_rst_m1_ready", 32'(m1_ready), 32'h0);
        check("async_rst_m0_rdata", m0_rdata, 32'h0);
        check("async_rst_m1_rdata", m1_rdata, 32'h0);
        check("async_rst_timeout_err", 32'(timeout_err), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // First tie after reset goes to m0
        slave_delay = 1; slave_data = 32'h0F0F0F0F;
        @(posedge clk); #1;
        push_acc(15'h0011, 4'h0, 32'h0, 2);
        push_acc(15'h0022, 4'h8, 32'hAB000000, 2);
        push_rsp(0, 32'h0F0F0F0F, 3, terr_exp);
        push_rsp(1, 32'h0F0F0F0F, -1, terr_exp);
        fork
            txn(0, 15'h0011, 4'h0, 32'h0);
            txn(1, 15'h0022, 4'h8, 32'hAB000000);
        join

        for (int i = 0; i < 50 && (acc_q.size() != 0 || rsp_q.size() != 0); i++) @(negedge clk);
        if (acc_q.size() != 0 || rsp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", acc_q.size(), rsp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
